axis2fifo_sink: RTL and testbench
=================================

Name: axis2fifo_sink

Overview:
- Downstream neighbour of the FIFO-to-AXI-Stream feeder.
- Acts as the AXI-Stream slave that consumes the HLS accelerator's result stream.
- Captures one packet (terminated by tlast) into an internal buffer, then drains it in order into a host-side FIFO write port.
- Reports completion, word count and overflow back to the controller.

Parameters:
- DATA_WIDTH, 32, width of stream data and FIFO write data.
- DEPTH, 4, buffer capacity in words; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of word_count; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  arm capture of one packet; sampled only in IDLE.
- m_axis_tdata  input  DATA_WIDTH  result data from accelerator.
- m_axis_tvalid  input  1  accelerator beat valid.
- m_axis_tready  output  1  sink ready.
- m_axis_tlast  input  1  last beat of packet.
- fifo_wdata  output  DATA_WIDTH  data to host FIFO.
- fifo_wen  output  1  write strobe; a write occurs on each rising edge where fifo_wen=1.
- fifo_full  input  1  host FIFO cannot accept a write this cycle.
- done  output  1  one-cycle pulse, packet fully written.
- word_count  output  CNT_W  number of words stored from the last packet (max DEPTH).
- overflow  output  1  sticky; packet exceeded DEPTH and excess beats were dropped.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; write and read pointers = 0.
  - Outputs: m_axis_tready=0, fifo_wen=0, fifo_wdata=0, done=0, word_count=0, overflow=0.
  - Buffer contents are don't-care.
  - A mid-operation reset aborts the packet immediately; no further writes occur.
- Beat accept: m_axis_tvalid && m_axis_tready at a rising edge. No X-filtering and no duplicate suppression; every accepted beat counts.
- States:
  - IDLE:
    - m_axis_tready=0.
    - start=1 -> RECV; clear write pointer, read pointer, word_count and overflow.
    - word_count and overflow from the previous packet hold until then.
  - RECV:
    - m_axis_tready=1, decoded from state (combinational, no bubble).
    - Accepted beat stores to buffer[wr_ptr]; wr_ptr+1; word_count+1.
    - Accepted beat with tlast=1 -> DRAIN. This applies even when the beat is the DEPTH-th; overflow stays 0.
    - DEPTH-th accepted beat with tlast=0 -> FLUSH.
  - FLUSH:
    - m_axis_tready=1; accepted beats are discarded; overflow=1.
    - word_count stays at DEPTH.
    - Accepted beat with tlast=1 -> DRAIN.
  - DRAIN:
    - fifo_wen = !fifo_full (combinational); fifo_wdata = buffer[rd_ptr] (combinational).
    - Each write increments rd_ptr.
    - Write of word index word_count-1 -> DONE.
    - fifo_full=1 stalls with no write; rd_ptr holds; no loss or duplication.
    - m_axis_tready=0.
  - DONE:
    - done=1 for exactly one cycle -> IDLE.
- Outside DRAIN: fifo_wen=0 and fifo_wdata=0.
- Latency: first fifo_wen is asserted the cycle after the tlast beat is accepted, given fifo_full=0.
- start is ignored in every state except IDLE.
- The pointer widths wrap naturally but never exceed DEPTH-1 in use.
- A zero-length packet is impossible, since tlast always accompanies a beat.

Test Plan:
1. DEPTH=4; start, then beats 0xA0..0xA3 with tlast on 0xA3 and fifo_full=0 -> 4 writes in order starting the next cycle, word_count=4, overflow=0, done pulses once, tready=0 afterwards.
2. 2-beat packet 0x11, 0x22 (tlast on 0x22) -> exactly 2 writes, word_count=2, done pulses the cycle after the second write.
3. 6-beat packet 0x1..0x6 with tlast on 0x6 -> 0x1..0x4 written, 0x5 and 0x6 accepted and dropped, overflow=1, word_count=4.
4. fifo_full=1 for 3 cycles after the first drain write -> fifo_wen=0 for those cycles, remaining words written once each with no gaps afterwards.
5. tvalid toggling 1,0,1,0 during RECV -> only valid beats stored, word_count matches, data order preserved.
6. rst_n pulsed low during DRAIN after 1 of 4 writes -> outputs reset immediately, no further fifo_wen, start required again, then a fresh packet drains correctly.

Source files
------------

// File: rtl/axis2fifo_sink_if.sv
// rtl/axis2fifo_sink_if.sv - result stream and host FIFO write port bundle for axis2fifo_sink
interface axis2fifo_sink_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic                  fifo_wen;
    logic                  fifo_full;

    // Producer/host side: drives the stream, observes the FIFO write port.
    modport master (
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, fifo_full,
        input  m_axis_tready, fifo_wdata, fifo_wen
    );

    // Sink side: consumes the stream, drives the FIFO write port.
    modport slave (
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, fifo_full,
        output m_axis_tready, fifo_wdata, fifo_wen
    );
endinterface

// File: rtl/axis2fifo_sink.sv
// rtl/axis2fifo_sink.sv - captures one AXI-Stream packet into a buffer, then drains it into a host FIFO
module axis2fifo_sink #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    axis2fifo_sink_if.slave  bus,
    output logic             done,
    output logic [CNT_W-1:0] word_count,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  beat;
    logic                  last_word;

    // Ready is decoded straight from state so the first beat after start is not delayed.
    assign bus.m_axis_tready = (state == S_RECV) || (state == S_FLUSH);
    assign beat              = bus.m_axis_tvalid && bus.m_axis_tready;

    // The FIFO sees the head word whenever draining; a full FIFO simply withholds the strobe.
    assign bus.fifo_wen   = (state == S_DRAIN) && !bus.fifo_full;
    assign bus.fifo_wdata = (state == S_DRAIN) ? mem[rd_ptr] : '0;

    // The word at rd_ptr is the final one of the stored packet.
    assign last_word = ({1'b0, rd_ptr} == (word_count - CNT_ONE));

    // Packet storage; contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (state == S_RECV && beat) begin
            mem[wr_ptr] <= bus.m_axis_tdata;
        end
    end

    // Capture/flush/drain sequencing with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            done       <= 1'b0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= S_RECV;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (beat) begin
                        wr_ptr     <= wr_ptr + PTR_ONE;
                        word_count <= word_count + CNT_ONE;
                        // tlast wins over a full buffer: an exact fit is not an overflow.
                        if (bus.m_axis_tlast) begin
                            state <= S_DRAIN;
                        end else if (word_count == LAST_SLOT) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (beat) begin
                        overflow <= 1'b1;
                        if (bus.m_axis_tlast) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!bus.fifo_full) begin
                        rd_ptr <= rd_ptr + PTR_ONE;
                        if (last_word) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis2fifo_sink.sv
// tb/tb_axis2fifo_sink.sv - self-checking bench for axis2fifo_sink with a packet-level scoreboard
module tb_axis2fifo_sink;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             done;
    logic [CNT_W-1:0] word_count;
    logic             overflow;

    axis2fifo_sink_if #(.DATA_WIDTH(DW)) bus ();

    axis2fifo_sink #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .done       (done),
        .word_count (word_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pkt[8];
    int  cyc           = 0;
    int  last_wr_cyc   = 0;
    int  last_done_cyc = 0;
    int  done_seen     = 0;
    logic prev_done    = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every FIFO write must match the next stored word, in order, exactly once.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.fifo_wen) begin
                last_wr_cyc = cyc;
                chk("wen_while_full", {31'b0, bus.fifo_full}, 32'd0);
                if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else chk("drain_data", bus.fifo_wdata, exp_q.pop_front());
            end
            if (done) begin
                done_seen++;
                last_done_cyc = cyc;
                if (prev_done) chk("done_width", 32'd2, 32'd1);
            end
        end
        prev_done = done;
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("tready_in_recv", {31'b0, bus.m_axis_tready}, 32'd1);
        @(posedge clk); #1;
    endtask

    // Sends n words from pkt[], tlast on the last; model keeps the first DEPTH words.
    task automatic send_packet(input int n, input bit gap);
        bit found;
        for (int i = 0; i < n; i++) begin
            bus.m_axis_tdata  = pkt[i];
            bus.m_axis_tvalid = 1'b1;
            bus.m_axis_tlast  = (i == n - 1);
            found = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.m_axis_tready) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("beat_accepted", {31'b0, found}, 32'd1);
            if (i < DEPTH) exp_q.push_back(pkt[i]);
            @(posedge clk); #1;
            bus.m_axis_tvalid = 1'b0;
            bus.m_axis_tlast  = 1'b0;
            if (gap && i != n - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input int exp_wc, input bit exp_ovf);
        bit found;
        int seen0;
        seen0 = done_seen;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        #1;
        chk("done_seen", {31'b0, found}, 32'd1);
        chk("done_count", done_seen - seen0, 32'd1);
        chk("done_after_last_write", last_done_cyc, last_wr_cyc + 1);
        chk("all_words_written", exp_q.size(), 32'd0);
        chk("word_count", {{(DW-CNT_W){1'b0}}, word_count}, exp_wc);
        chk("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
        @(negedge clk);
        chk("done_dropped", {31'b0, done}, 32'd0);
        chk("tready_idle", {31'b0, bus.m_axis_tready}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n             = 1'b0;
        start             = 1'b0;
        bus.m_axis_tdata  = '0;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tlast  = 1'b0;
        bus.fifo_full     = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_tready", {31'b0, bus.m_axis_tready}, 32'd0);
        chk("rst_wen", {31'b0, bus.fifo_wen}, 32'd0);
        chk("rst_wdata", bus.fifo_wdata, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_word_count", {{(DW-CNT_W){1'b0}}, word_count}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: exact-fit packet, first write the cycle after tlast
        pkt[0] = 32'hA0; pkt[1] = 32'hA1; pkt[2] = 32'hA2; pkt[3] = 32'hA3;
        do_start();
        send_packet(4, 1'b0);
        @(negedge clk);
        chk("first_write_latency", {31'b0, bus.fifo_wen}, 32'd1);
        chk("first_write_data", bus.fifo_wdata, 32'hA0);
        chk("tready_in_drain", {31'b0, bus.m_axis_tready}, 32'd0);
        wait_done(4, 1'b0);

        // 2: short packet
        pkt[0] = 32'h11; pkt[1] = 32'h22;
        do_start();
        send_packet(2, 1'b0);
        wait_done(2, 1'b0);

        // 3: oversize packet, excess dropped
        for (int i = 0; i < 6; i++) pkt[i] = 32'(i + 1);
        do_start();
        send_packet(6, 1'b0);
        wait_done(4, 1'b1);

        // 4: FIFO full stalls for three cycles after the first write
        pkt[0] = 32'hC1; pkt[1] = 32'hC2; pkt[2] = 32'hC3; pkt[3] = 32'hC4;
        do_start();
        send_packet(4, 1'b0);
        @(negedge clk);
        chk("stall_first_write", {31'b0, bus.fifo_wen}, 32'd1);
        @(posedge clk); #1;
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_no_wen", {31'b0, bus.fifo_wen}, 32'd0);
            @(posedge clk); #1;
        end
        bus.fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("resume_no_gap", {31'b0, bus.fifo_wen}, 32'd1);
            @(posedge clk); #1;
        end
        wait_done(4, 1'b0);

        // 5: tvalid toggling during capture
        pkt[0] = 32'h31; pkt[1] = 32'h32; pkt[2] = 32'h33;
        do_start();
        send_packet(3, 1'b1);
        wait_done(3, 1'b0);

        // 6: reset during drain after one write
        pkt[0] = 32'h51; pkt[1] = 32'h52; pkt[2] = 32'h53; pkt[3] = 32'h54;
        do_start();
        send_packet(4, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_wen", {31'b0, bus.fifo_wen}, 32'd0);
        chk("midrst_wdata", bus.fifo_wdata, 32'd0);
        chk("midrst_word_count", {{(DW-CNT_W){1'b0}}, word_count}, 32'd0);
        chk("midrst_tready", {31'b0, bus.m_axis_tready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.m_axis_tdata  = 32'hEE;
        bus.m_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_start_no_tready", {31'b0, bus.m_axis_tready}, 32'd0);
            chk("no_write_after_rst", {31'b0, bus.fifo_wen}, 32'd0);
        end
        @(posedge clk); #1;
        bus.m_axis_tvalid = 1'b0;
        pkt[0] = 32'h61; pkt[1] = 32'h62; pkt[2] = 32'h63; pkt[3] = 32'h64;
        do_start();
        send_packet(4, 1'b0);
        wait_done(4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
